// File: rtl/cnn_pkg.sv
// Shared CNN inference-path definitions: Q1.15 limits, clog2 helper and the
// classifier FSM state encoding.
package cnn_pkg;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/dense_argmax_if.sv
// Bus between the dense layer / host side and the argmax classifier.
// DENSE_ARGMAX_TOP2_EN adds the runner-up index and margin signals.
interface dense_argmax_if #(
    parameter int unsigned N     = 100,
    parameter int unsigned IDX_W = 7
) ();

    logic [16*N-1:0] y;
    logic            resting;
    logic [IDX_W-1:0] class_idx;
    logic [15:0]     max_val;
    logic            valid;
    logic            busy;
    logic            overrun;
`ifdef DENSE_ARGMAX_TOP2_EN
    logic [IDX_W-1:0] second_idx;
    logic [15:0]     margin;
`endif

    modport master (
        output y, resting,
        input  class_idx, max_val, valid, busy, overrun
`ifdef DENSE_ARGMAX_TOP2_EN
        , input second_idx, margin
`endif
    );

    modport slave (
        input  y, resting,
        output class_idx, max_val, valid, busy, overrun
`ifdef DENSE_ARGMAX_TOP2_EN
        , output second_idx, margin
`endif
    );

endinterface

// File: rtl/argmax_lane_reduce.sv
// Combinational LANES-wide max reduction with lane mask and base index; ties keep
// the lowest index. DENSE_ARGMAX_TOP2_EN also yields the local runner-up.
module argmax_lane_reduce
    import cnn_pkg::*;
#(
    parameter int unsigned LANES = 10,
    parameter int unsigned IDX_W = 7
) (
    input  logic [16*LANES-1:0] vals,
    input  logic [LANES-1:0]    mask,
    input  logic [IDX_W-1:0]    base,
    output logic signed [15:0]  max_val,
    output logic [IDX_W-1:0]    max_idx,
    output logic                max_vld
`ifdef DENSE_ARGMAX_TOP2_EN
    ,
    output logic signed [15:0]  sec_val,
    output logic [IDX_W-1:0]    sec_idx,
    output logic                sec_vld
`endif
);

    logic signed [15:0] v;
    logic [IDX_W-1:0]   vi;

    always_comb begin
        max_val = Q15_MIN;
        max_idx = '0;
        max_vld = 1'b0;
`ifdef DENSE_ARGMAX_TOP2_EN
        sec_val = Q15_MIN;
        sec_idx = '0;
        sec_vld = 1'b0;
`endif
        v  = '0;
        vi = '0;
        // Lanes are visited in ascending index order, so strict compares keep the earlier lane on ties.
        for (int unsigned l = 0; l < LANES; l++) begin
            v  = vals[16*l +: 16];
            vi = base + IDX_W'(l);
            if (mask[l]) begin
                if (!max_vld || v > max_val) begin
`ifdef DENSE_ARGMAX_TOP2_EN
                    sec_val = max_val;
                    sec_idx = max_idx;
                    sec_vld = max_vld;
`endif
                    max_val = v;
                    max_idx = vi;
                    max_vld = 1'b1;
                end
`ifdef DENSE_ARGMAX_TOP2_EN
                else if (!sec_vld || v > sec_val) begin
                    sec_val = v;
                    sec_idx = vi;
                    sec_vld = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/dense_argmax.sv
// Argmax classifier after the dense layer: captures y on a rising resting edge,
// scans LANES elements per cycle and reports index/value of the maximum.
// Optional DENSE_ARGMAX_TOP2_EN adds runner-up index and saturated margin.
module dense_argmax
    import cnn_pkg::*;
#(
    parameter int unsigned N     = 100,
    parameter int unsigned LANES = 10,
    parameter int unsigned IDX_W = 7,
    parameter int unsigned ITERS = 10
) (
    input logic           clk,
    input logic           rst,
    dense_argmax_if.slave bus
);

    localparam int unsigned ITER_W = (clog2(ITERS) > 0) ? clog2(ITERS) : 1;
    localparam int unsigned BIT_W  = clog2(16 * N);

    state_t             state, state_nxt;
    logic               resting_q, start, last;
    logic [16*N-1:0]    buf_q;
    logic [ITER_W-1:0]  iter;
    logic signed [15:0] best_val;
    logic [IDX_W-1:0]   best_idx;
    logic               best_vld;
    logic [IDX_W-1:0]   class_idx_q;
    logic [15:0]        max_val_q;
    logic               valid_q, busy_q, overrun_q;

    logic [16*LANES-1:0] lane_vals;
    logic [LANES-1:0]    lane_mask;
    logic [IDX_W-1:0]    base;
    logic [BIT_W-1:0]    bit_pos;
    logic signed [15:0]  loc_val, nb_val;
    logic [IDX_W-1:0]    loc_idx, nb_idx;
    logic                loc_vld, nb_vld, take_local;

`ifdef DENSE_ARGMAX_TOP2_EN
    logic signed [15:0] sec_val, loc2_val, ns_val;
    logic [IDX_W-1:0]   sec_idx, loc2_idx, ns_idx;
    logic               sec_vld, loc2_vld, ns_vld;
    logic signed [16:0] diff;
    logic [15:0]        margin_nxt;
    logic [IDX_W-1:0]   second_idx_q;
    logic [15:0]        margin_q;
`endif

    assign start = bus.resting & ~resting_q;
    assign last  = (iter == ITER_W'(ITERS - 1));
    assign base  = IDX_W'(32'(iter) * LANES);

    always_comb begin
        lane_vals = '0;
        lane_mask = '0;
        bit_pos   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (32'(iter) * LANES + l < N) begin
                bit_pos                = BIT_W'(16 * (32'(iter) * LANES + l));
                lane_mask[l]           = 1'b1;
                lane_vals[16*l +: 16]  = buf_q[bit_pos +: 16];
            end
        end
    end

    argmax_lane_reduce #(
        .LANES(LANES),
        .IDX_W(IDX_W)
    ) u_reduce (
        .vals   (lane_vals),
        .mask   (lane_mask),
        .base   (base),
        .max_val(loc_val),
        .max_idx(loc_idx),
        .max_vld(loc_vld)
`ifdef DENSE_ARGMAX_TOP2_EN
        ,
        .sec_val(loc2_val),
        .sec_idx(loc2_idx),
        .sec_vld(loc2_vld)
`endif
    );

    always_comb begin
        take_local = loc_vld && (!best_vld || loc_val > best_val);
        nb_val     = take_local ? loc_val : best_val;
        nb_idx     = take_local ? loc_idx : best_idx;
        nb_vld     = best_vld | loc_vld;
`ifdef DENSE_ARGMAX_TOP2_EN
        // Running entries always have lower indices than the current lanes, so they win ties.
        if (take_local) begin
            if (loc2_vld && (!best_vld || loc2_val > best_val)) begin
                ns_val = loc2_val; ns_idx = loc2_idx; ns_vld = 1'b1;
            end else begin
                ns_val = best_val; ns_idx = best_idx; ns_vld = best_vld;
            end
        end else if (loc_vld && (!sec_vld || loc_val > sec_val)) begin
            ns_val = loc_val; ns_idx = loc_idx; ns_vld = 1'b1;
        end else begin
            ns_val = sec_val; ns_idx = sec_idx; ns_vld = sec_vld;
        end
        diff = $signed({nb_val[15], nb_val}) - $signed({ns_val[15], ns_val});
        if (!ns_vld || diff > 17'sh07FFF) margin_nxt = Q15_MAX;
        else                              margin_nxt = diff[15:0];
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resting_q   <= 1'b0;
            buf_q       <= '0;
            iter        <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            best_vld    <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DENSE_ARGMAX_TOP2_EN
            sec_val      <= '0;
            sec_idx      <= '0;
            sec_vld      <= 1'b0;
            second_idx_q <= '0;
            margin_q     <= '0;
`endif
        end else begin
            resting_q <= bus.resting;
            valid_q   <= 1'b0;
            if (start && state != IDLE) overrun_q <= 1'b1;
            unique case (state)
                IDLE: if (start) begin
                    buf_q    <= bus.y;
                    iter     <= '0;
                    best_val <= Q15_MIN;
                    best_idx <= '0;
                    best_vld <= 1'b0;
                    busy_q   <= 1'b1;
`ifdef DENSE_ARGMAX_TOP2_EN
                    sec_val  <= Q15_MIN;
                    sec_idx  <= '0;
                    sec_vld  <= 1'b0;
`endif
                end
                SCAN: begin
                    best_val <= nb_val;
                    best_idx <= nb_idx;
                    best_vld <= nb_vld;
`ifdef DENSE_ARGMAX_TOP2_EN
                    sec_val  <= ns_val;
                    sec_idx  <= ns_idx;
                    sec_vld  <= ns_vld;
`endif
                    if (last) begin
                        class_idx_q <= nb_idx;
                        max_val_q   <= nb_val;
                        valid_q     <= 1'b1;
`ifdef DENSE_ARGMAX_TOP2_EN
                        second_idx_q <= ns_idx;
                        margin_q     <= margin_nxt;
`endif
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DONE:    busy_q <= 1'b0;
                default: busy_q <= 1'b0;
            endcase
        end
    end

    assign bus.class_idx = class_idx_q;
    assign bus.max_val   = max_val_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
`ifdef DENSE_ARGMAX_TOP2_EN
    assign bus.second_idx = second_idx_q;
    assign bus.margin     = margin_q;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Scoreboard bench for dense_argmax (N=100 and N=95 instances); expected results are
// queued at stimulus time and popped by a monitor on each valid pulse.
module tb_dense_argmax;

    localparam int ITERS = 10;

    typedef struct packed {
        logic [6:0]  idx;
        logic [15:0] val;
        logic [6:0]  sidx;
        logic [15:0] marg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dense_argmax_if #(.N(100), .IDX_W(7)) ba ();
    dense_argmax_if #(.N(95),  .IDX_W(7)) bb ();

    dense_argmax #(.N(100), .LANES(10), .IDX_W(7), .ITERS(10)) dut (
        .clk(clk), .rst(rst), .bus(ba.slave));
    dense_argmax #(.N(95), .LANES(10), .IDX_W(7), .ITERS(10)) dut95 (
        .clk(clk), .rst(rst), .bus(bb.slave));

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int failures = 0;
    logic [15:0] el [100];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ba.valid) begin
            if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qa.pop_front();
                check("a_class_idx", 32'(ba.class_idx), 32'(e.idx));
                check("a_max_val", 32'(ba.max_val), 32'(e.val));
`ifdef DENSE_ARGMAX_TOP2_EN
                check("a_second_idx", 32'(ba.second_idx), 32'(e.sidx));
                check("a_margin", 32'(ba.margin), 32'(e.marg));
`endif
            end
        end
        if (rst && bb.valid) begin
            if (qb.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qb.pop_front();
                check("b_class_idx", 32'(bb.class_idx), 32'(e.idx));
                check("b_max_val", 32'(bb.max_val), 32'(e.val));
`ifdef DENSE_ARGMAX_TOP2_EN
                check("b_second_idx", 32'(bb.second_idx), 32'(e.sidx));
                check("b_margin", 32'(bb.margin), 32'(e.marg));
`endif
            end
        end
    end

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < 100; k++) el[k] = v;
    endtask

    task automatic load(input bit sel);
        for (int k = 0; k < 100; k++) begin
            if (sel) begin
                if (k < 95) bb.y[16*k +: 16] = el[k];
            end else begin
                ba.y[16*k +: 16] = el[k];
            end
        end
    endtask

    task automatic pulse(input bit sel);
        @(posedge clk); #1;
        if (sel) bb.resting = 1'b1; else ba.resting = 1'b1;
        @(posedge clk); #1;
        if (sel) bb.resting = 1'b0; else ba.resting = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!(sel ? bb.valid : ba.valid) && cnt < 40);
    endtask

    task automatic run(input string name, input bit sel, input exp_t e);
        int cnt;
        load(sel);
        if (sel) qb.push_back(e); else qa.push_back(e);
        pulse(sel);
        wait_valid(sel, cnt);
        check({name, "_latency"}, 32'(cnt), 32'(ITERS));
        check({name, "_busy_in_valid"}, 32'(sel ? bb.busy : ba.busy), 32'd1);
        @(posedge clk); #1;
        check({name, "_valid_cleared"}, 32'(sel ? bb.valid : ba.valid), 32'd0);
        check({name, "_busy_cleared"}, 32'(sel ? bb.busy : ba.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt, nv;
        ba.resting = 1'b0; ba.y = '0;
        bb.resting = 1'b0; bb.y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_class_idx", 32'(ba.class_idx), 32'd0);
        check("rst_max_val", 32'(ba.max_val), 32'd0);
        check("rst_valid", 32'(ba.valid), 32'd0);
        check("rst_busy", 32'(ba.busy), 32'd0);
        check("rst_overrun", 32'(ba.overrun), 32'd0);
        rst = 1'b1;

        // Single dominant element
        fill(16'h0100); el[37] = 16'h4000;
        run("t1", 1'b0, '{7'd37, 16'h4000, 7'd0, 16'h3F00});
        repeat (3) @(posedge clk); #1;
        check("t1_hold_idx", 32'(ba.class_idx), 32'd37);

        fill(16'h0000); el[5] = 16'h7FFF; el[82] = 16'h7FFF;
        run("t2_tie", 1'b0, '{7'd5, 16'h7FFF, 7'd82, 16'h0000});

        for (int k = 0; k < 99; k++) el[k] = 16'h8000 + 16'(k) * 16'h0100;
        el[99] = 16'hFFFF;
        run("t3_neg", 1'b0, '{7'd99, 16'hFFFF, 7'd98, 16'h1DFF});

        fill(16'h8000);
        run("t3_min", 1'b0, '{7'd0, 16'h8000, 7'd1, 16'h0000});

        fill(16'h0000); el[3] = 16'h6000; el[60] = 16'h2000;
        run("t6_top2", 1'b0, '{7'd3, 16'h6000, 7'd60, 16'h4000});

        fill(16'h8000); el[42] = 16'h7FFF;
        run("t6_sat", 1'b0, '{7'd42, 16'h7FFF, 7'd0, 16'h7FFF});

        // resting held high gives exactly one capture
        for (int k = 0; k < 100; k++) el[k] = 16'(k);
        load(1'b0);
        qa.push_back('{7'd99, 16'h0063, 7'd98, 16'h0001});
        @(posedge clk); #1 ba.resting = 1'b1;
        @(posedge clk); #1;
        wait_valid(1'b0, cnt);
        check("held_latency", 32'(cnt), 32'(ITERS));
        nv = 0;
        repeat (20) begin @(posedge clk); #1; if (ba.valid) nv++; end
        check("held_single_start", 32'(nv), 32'd0);
        check("held_busy", 32'(ba.busy), 32'd0);
        check("held_overrun", 32'(ba.overrun), 32'd0);
        ba.resting = 1'b0;

        // Back-to-back: second start in the IDLE-return cycle
        fill(16'h1000); el[0] = 16'h7000;
        load(1'b0);
        qa.push_back('{7'd0, 16'h7000, 7'd1, 16'h6000});
        pulse(1'b0);
        wait_valid(1'b0, cnt);
        check("b2b_first_latency", 32'(cnt), 32'(ITERS));
        fill(16'h0000); el[77] = 16'h0123; el[13] = 16'h0122;
        load(1'b0);
        qa.push_back('{7'd77, 16'h0123, 7'd13, 16'h0001});
        @(posedge clk); #1 ba.resting = 1'b1;
        @(posedge clk); #1 ba.resting = 1'b0;
        check("b2b_accepted", 32'(ba.busy), 32'd1);
        wait_valid(1'b0, cnt);
        check("b2b_second_latency", 32'(cnt), 32'(ITERS));
        check("b2b_overrun", 32'(ba.overrun), 32'd0);
        @(posedge clk); #1;

        // N=95: lanes 95..99 masked in the last scan cycle
        fill(16'h0800); el[94] = 16'h1000;
        run("t4_n95", 1'b1, '{7'd94, 16'h1000, 7'd0, 16'h0800});
        fill(16'h9000); el[94] = 16'hFFF0;
        run("t4_n95_neg", 1'b1, '{7'd94, 16'hFFF0, 7'd0, 16'h6FF0});

        // Overrun at scan cycle 4; y changes after capture are ignored
        fill(16'h0000); el[10] = 16'h0500;
        load(1'b0);
        qa.push_back('{7'd10, 16'h0500, 7'd0, 16'h0500});
        pulse(1'b0);
        repeat (3) @(posedge clk);
        #1 ba.resting = 1'b1;
        el[20] = 16'h7FFF; load(1'b0);
        @(posedge clk); #1 ba.resting = 1'b0;
        check("t5_overrun_set", 32'(ba.overrun), 32'd1);
        wait_valid(1'b0, cnt);
        check("t5_latency", 32'(cnt), 32'(ITERS - 4));
        @(posedge clk); #1;
        check("t5_overrun_sticky", 32'(ba.overrun), 32'd1);

        // Reset at scan cycle 6 aborts the scan
        fill(16'h0000); el[50] = 16'h3000;
        load(1'b0);
        pulse(1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_class_idx", 32'(ba.class_idx), 32'd0);
        check("t5_rst_max_val", 32'(ba.max_val), 32'd0);
        check("t5_rst_valid", 32'(ba.valid), 32'd0);
        check("t5_rst_busy", 32'(ba.busy), 32'd0);
        check("t5_rst_overrun", 32'(ba.overrun), 32'd0);
`ifdef DENSE_ARGMAX_TOP2_EN
        check("t5_rst_second_idx", 32'(ba.second_idx), 32'd0);
        check("t5_rst_margin", 32'(ba.margin), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        nv = 0;
        repeat (20) begin @(posedge clk); #1; if (ba.valid) nv++; end
        check("t5_no_valid_after_abort", 32'(nv), 32'd0);
        check("t5_idle_busy", 32'(ba.busy), 32'd0);

        check("scoreboard_a_drained", 32'(qa.size()), 32'd0);
        check("scoreboard_b_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
